// File: rtl/digit_bank.sv
// Bank of 32 editable digits with one-hot increment, sticky multi-hot error,
// and a slow_clock-paced scan-out that blinks the digit under the edit cursor.
module digit_bank #(
  parameter int unsigned MODULUS   = 10,
  parameter int unsigned BLINK_BIT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         slow_clock,
  input  logic [31:0]  doInc,
  input  logic [4:0]   digit,
  input  logic         clear,
  output logic [4:0]   scan_idx,
  output logic [3:0]   scan_val,
  output logic         scan_blank,
  output logic [127:0] digits_flat,
  output logic         onehot_err
);

  localparam logic [3:0] MaxVal = 4'(MODULUS - 1);

  logic [3:0] digits_q [32];
  logic [3:0] digits_d [32];
  logic [4:0] scan_q, scan_d;
  logic [7:0] blink_q, blink_d;
  logic       err_q, err_d;
  logic       inc_multi;

  always_comb begin
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    inc_multi = (doInc & (doInc - 32'd1)) != 32'd0;
    digits_d  = digits_q;
    err_d     = err_q;
    if (clear) begin
      for (int n = 0; n < 32; n++) digits_d[n] = 4'd0;
      err_d = 1'b0;
    end else if (slow_clock) begin
      if (inc_multi) begin
        err_d = 1'b1;
      end else begin
        for (int n = 0; n < 32; n++) begin
          // >= also folds any out-of-range value back to zero.
          if (doInc[n]) digits_d[n] = (digits_q[n] >= MaxVal) ? 4'd0 : digits_q[n] + 4'd1;
        end
      end
    end
    scan_d  = slow_clock ? scan_q + 5'd1 : scan_q;
    blink_d = slow_clock ? blink_q + 8'd1 : blink_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 32; n++) digits_q[n] <= 4'd0;
      scan_q  <= 5'd0;
      blink_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      scan_q   <= scan_d;
      blink_q  <= blink_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    digits_flat = '0;
    for (int n = 0; n < 32; n++) digits_flat[4*n +: 4] = digits_q[n];
  end

  assign scan_idx   = scan_q;
  assign scan_val   = digits_q[scan_q];
  assign scan_blank = (scan_q == digit) && blink_q[BLINK_BIT];
  assign onehot_err = err_q;

endmodule

// File: tb/tb_digit_bank.sv
// Self-checking bench for digit_bank: behavioural model feeds a scoreboard queue.
module tb_digit_bank;

  logic         clk = 1'b0;
  logic         reset, slow_clock, clear;
  logic [31:0]  doInc;
  logic [4:0]   digit;
  logic [4:0]   scan_idx, scan_idx16;
  logic [3:0]   scan_val, scan_val16;
  logic         scan_blank, scan_blank16;
  logic [127:0] digits_flat, digits_flat16;
  logic         onehot_err, onehot_err16;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [127:0] flat;
    logic [4:0]   idx;
    logic [7:0]   blink;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   m_dig [32];
  int   m_idx, m_blink;
  logic m_err;

  always #5 clk = ~clk;

  digit_bank #(.MODULUS(10), .BLINK_BIT(3)) dut (
    .clk(clk), .reset(reset), .slow_clock(slow_clock), .doInc(doInc), .digit(digit),
    .clear(clear), .scan_idx(scan_idx), .scan_val(scan_val), .scan_blank(scan_blank),
    .digits_flat(digits_flat), .onehot_err(onehot_err)
  );

  digit_bank #(.MODULUS(16), .BLINK_BIT(3)) dut16 (
    .clk(clk), .reset(reset), .slow_clock(slow_clock), .doInc(doInc), .digit(digit),
    .clear(clear), .scan_idx(scan_idx16), .scan_val(scan_val16), .scan_blank(scan_blank16),
    .digits_flat(digits_flat16), .onehot_err(onehot_err16)
  );

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 32; i++) f[4*i +: 4] = 4'(m_dig[i]);
    return f;
  endfunction

  // Drive one cycle, advance the model, push the expectation, then step past the edge.
  task automatic step(input logic sc, input logic [31:0] inc, input logic clr, input logic rst);
    exp_t e;
    slow_clock = sc;
    doInc      = inc;
    clear      = clr;
    reset      = rst;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_dig[i] = 0;
      m_idx = 0; m_blink = 0; m_err = 1'b0;
    end else begin
      if (clr) begin
        for (int i = 0; i < 32; i++) m_dig[i] = 0;
        m_err = 1'b0;
      end else if (sc) begin
        if ($countones(inc) > 1) m_err = 1'b1;
        else if ($countones(inc) == 1)
          for (int n = 0; n < 32; n++) if (inc[n]) m_dig[n] = (m_dig[n] + 1) % 10;
      end
      if (sc) begin
        m_idx   = (m_idx + 1) % 32;
        m_blink = (m_blink + 1) % 256;
      end
    end
    e.flat  = model_flat();
    e.idx   = 5'(m_idx);
    e.blink = 8'(m_blink);
    e.err   = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    slow_clock = 1'b0; doInc = '0; clear = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    void'(sb.pop_front());
    checks++; if (digits_flat !== 128'h0) $display("FAIL reset_flat got %h want 0", digits_flat);
              else passes++;
    checks++; if (scan_idx !== 5'd0) $display("FAIL reset_idx got %0d want 0", scan_idx);
              else passes++;
    checks++; if (scan_val !== 4'd0) $display("FAIL reset_val got %0d want 0", scan_val);
              else passes++;
    checks++; if (scan_blank !== 1'b0) $display("FAIL reset_blank got %b want 0", scan_blank);
              else passes++;
    checks++; if (onehot_err !== 1'b0) $display("FAIL reset_err got %b want 0", onehot_err);
              else passes++;
  endtask

  task automatic test_wrap();
    exp_t e;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0000_0004, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (digits_flat !== e.flat)
                  $display("FAIL wrap_flat step %0d got %h want %h", i, digits_flat, e.flat);
                else passes++;
      checks++; if (digits_flat[11:8] !== 4'((i + 1) % 10))
                  $display("FAIL wrap_d2 step %0d got %0d want %0d", i, digits_flat[11:8],
                           (i + 1) % 10);
                else passes++;
    end
  endtask

  task automatic test_multihot();
    exp_t e;
    step(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++; if (digits_flat !== e.flat) $display("FAIL multi_flat got %h want %h",
                                                   digits_flat, e.flat);
              else passes++;
    checks++; if (onehot_err !== 1'b1) $display("FAIL multi_err got %b want 1", onehot_err);
              else passes++;
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++; if (digits_flat[3:0] !== 4'd1) $display("FAIL multi_legal_d0 got %0d want 1",
                                                      digits_flat[3:0]);
              else passes++;
    checks++; if (onehot_err !== e.err) $display("FAIL multi_sticky got %b want %b",
                                                 onehot_err, e.err);
              else passes++;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++; if (digits_flat !== e.flat) $display("FAIL clear_flat got %h want %h",
                                                   digits_flat, e.flat);
              else passes++;
    checks++; if (onehot_err !== 1'b0) $display("FAIL clear_err got %b want 0", onehot_err);
              else passes++;
  endtask

  task automatic test_ungated();
    exp_t e;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h8000_0003, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (digits_flat !== e.flat)
                  $display("FAIL ungated_flat cyc %0d got %h want %h", i, digits_flat, e.flat);
                else passes++;
      checks++; if (scan_idx !== e.idx || onehot_err !== e.err)
                  $display("FAIL ungated_idx_err cyc %0d got %0d/%b want %0d/%b", i, scan_idx,
                           onehot_err, e.idx, e.err);
                else passes++;
    end
  endtask

  task automatic test_scan_blink();
    exp_t e;
    logic [127:0] f;
    logic exp_blank;
    digit = 5'd5;
    for (int i = 0; i < 512; i++) begin
      step(1'b1, (i < 100) ? (32'h1 << ((i * 7) % 32)) : 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      f = e.flat;
      exp_blank = (e.idx == 5'd5) && e.blink[3];
      checks++; if (scan_idx !== e.idx)
                  $display("FAIL scan_idx strobe %0d got %0d want %0d", i, scan_idx, e.idx);
                else passes++;
      checks++; if (scan_blank !== exp_blank)
                  $display("FAIL scan_blank strobe %0d got %b want %b", i, scan_blank, exp_blank);
                else passes++;
      checks++; if (scan_val !== f[4*e.idx +: 4])
                  $display("FAIL scan_val strobe %0d got %0d want %0d", i, scan_val,
                           f[4*e.idx +: 4]);
                else passes++;
    end
    // Cursor moves combinationally onto the current scan position.
    digit = scan_idx;
    #1;
    checks++; if (scan_blank !== e.blink[3])
                $display("FAIL blank_comb got %b want %b", scan_blank, e.blink[3]);
              else passes++;
    digit = 5'd5;
  endtask

  task automatic test_priority();
    exp_t e;
    step(1'b1, 32'h0000_0001, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++; if (digits_flat !== e.flat || digits_flat[3:0] !== 4'd0)
                $display("FAIL clear_prio got %h want %h", digits_flat, e.flat);
              else passes++;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 32'h0000_0080, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'h0000_0200, 1'b0, 1'b0);
      e = sb.pop_front();
    end
    checks++; if (digits_flat !== e.flat)
                $display("FAIL load_7_9 got %h want %h", digits_flat, e.flat);
              else passes++;
    step(1'b1, 32'h0000_0008, 1'b0, 1'b1);
    void'(sb.pop_front());
    checks++; if (digits_flat !== 128'h0 || scan_idx !== 5'd0 || scan_val !== 4'd0 ||
                  scan_blank !== 1'b0 || onehot_err !== 1'b0)
                $display("FAIL reset_prio got flat=%h idx=%0d val=%0d blank=%b err=%b want 0s",
                         digits_flat, scan_idx, scan_val, scan_blank, onehot_err);
              else passes++;
  endtask

  task automatic test_mod16();
    exp_t e;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h8000_0000, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++; if (digits_flat16[127:124] !== 4'((i + 1) % 16))
                  $display("FAIL mod16_d31 step %0d got %0d want %0d", i, digits_flat16[127:124],
                           (i + 1) % 16);
                else passes++;
      checks++; if (digits_flat !== e.flat)
                  $display("FAIL mod10_d31 step %0d got %h want %h", i, digits_flat, e.flat);
                else passes++;
    end
  endtask

  initial begin
    reset = 1'b1; slow_clock = 1'b0; clear = 1'b0; doInc = '0; digit = 5'd0;
    test_reset();
    test_wrap();
    test_multihot();
    test_ungated();
    test_scan_blink();
    test_priority();
    test_mod16();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
